seven_seg_scan_driver: RTL



---
 rtl/seven_seg_pkg.sv | 41 ++++
 rtl/seven_seg_font.sv | 20 ++
 rtl/seven_seg_scan_driver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: font table,
// segment/anode polarities and a width helper for the scan counters.
package seven_seg_pkg;

    // All segments dark, including the decimal point (active-low pins).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Common-anode display: an anode is switched off by driving it high.
    localparam logic ANODE_OFF = 1'b1;

    // Hex font, segments {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] FONT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0011000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/seven_seg_font.sv
// Nibble-to-segment decoder: hex nibble, dot request and blank request
// become one active-low {dp,g,f,e,d,c,b,a} pattern.
module seven_seg_font
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    input  logic       blank,
    output logic [7:0] pattern
);

    // Blank overrides both the glyph and the decimal point.
    always_comb begin
        pattern = {~dot, FONT[nibble]};
        if (blank) begin
            pattern = SEG_OFF;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Self-scanning driver for an N-digit common-anode seven-segment display.
// A prescaler divides each digit slot into CLK_DIV cycles; the first
// GUARD_CYCLES of every slot keep all anodes off so the segment lines can
// settle on the new digit (anti-ghosting). Inputs are snapshotted once per
// scan so a full refresh always shows one coherent value. Brightness is a
// 16-step PWM gate on the anodes. All pins are driven from registers.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [4*NUM_DIGITS-1:0] DIGITS_IN,
    input  logic [NUM_DIGITS-1:0]   DOTS_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK_IN,
    input  logic                    LZ_SUPPRESS_IN,
    input  logic [3:0]              BRIGHT_IN,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT,
    output logic                    SCAN_START_OUT
);

    localparam int CNT_W = clog2(CLK_DIV);
    localparam int IDX_W = clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] GUARD_END  = CNT_W'(GUARD_CYCLES);

    // Scan state
    logic [CNT_W-1:0] presc;
    logic [IDX_W-1:0] idx;
    logic [3:0]       phase;

    // Per-scan input snapshot
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dots;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;
    logic [3:0]              snap_bright;

    // Snapshot view used this cycle (live inputs on the capture cycle)
    logic                    scan_entry;
    logic [4*NUM_DIGITS-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]   eff_dots;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic                    eff_lz;
    logic [3:0]              eff_bright;

    // Current-digit decode
    logic [NUM_DIGITS-1:0]   suppress_vec;
    logic                    zero_above;
    logic [3:0]              cur_nibble;
    logic                    cur_dot;
    logic                    cur_blank;
    logic                    cur_suppress;
    logic [7:0]              font_pat;
    logic                    cur_dark;
    logic                    pwm_gate;
    logic                    anode_en;
    logic [7:0]              hex_next;
    logic [NUM_DIGITS-1:0]   sel_next;

    // Slot 0, cycle 0 is where a new scan begins and the snapshot is taken.
    assign scan_entry = (presc == '0) && (idx == '0);

    // Slot prescaler and digit index; reset restarts at digit 0, cycle 0.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Free-running brightness PWM phase.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            phase <= 4'h0;
        end else begin
            phase <= phase + 4'h1;
        end
    end

    // Capture all display inputs once per scan, on entry to digit 0.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            snap_digits <= '0;
            snap_dots   <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
            snap_bright <= 4'h0;
        end else if (scan_entry) begin
            snap_digits <= DIGITS_IN;
            snap_dots   <= DOTS_IN;
            snap_blank  <= BLANK_IN;
            snap_lz     <= LZ_SUPPRESS_IN;
            snap_bright <= BRIGHT_IN;
        end
    end

    // On the capture cycle the registers still hold the old scan, so the
    // digit 0 cycle 0 decode reads the values being captured instead.
    always_comb begin
        eff_digits = snap_digits;
        eff_dots   = snap_dots;
        eff_blank  = snap_blank;
        eff_lz     = snap_lz;
        eff_bright = snap_bright;
        if (scan_entry) begin
            eff_digits = DIGITS_IN;
            eff_dots   = DOTS_IN;
            eff_blank  = BLANK_IN;
            eff_lz     = LZ_SUPPRESS_IN;
            eff_bright = BRIGHT_IN;
        end
    end

    // Digit i>0 is a leading zero when it and every digit left of it is 0.
    always_comb begin
        zero_above   = 1'b1;
        suppress_vec = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above      = zero_above & (eff_digits[4*i +: 4] == 4'h0);
            suppress_vec[i] = eff_lz & zero_above;
        end
    end

    // Select the fields of the digit whose slot is active.
    always_comb begin
        cur_nibble   = eff_digits[4*int'(idx) +: 4];
        cur_dot      = eff_dots[idx];
        cur_blank    = eff_blank[idx];
        cur_suppress = suppress_vec[idx];
    end

    seven_seg_font u_font (
        .nibble  (cur_nibble),
        .dot     (cur_dot),
        .blank   (cur_blank),
        .pattern (font_pat)
    );

    // A suppressed digit keeps its dot; a digit with nothing lit stays dark.
    always_comb begin
        hex_next = font_pat;
        if (cur_suppress) begin
            hex_next = {font_pat[7], 7'h7F};
        end
        cur_dark = cur_blank | (cur_suppress & ~cur_dot);
        pwm_gate = (phase <= eff_bright);
        anode_en = (presc >= GUARD_END) && pwm_gate && !cur_dark;
        sel_next = {NUM_DIGITS{ANODE_OFF}};
        if (anode_en) begin
            sel_next[idx] = ~ANODE_OFF;
        end
    end

    // Register every pin so no input reaches the display combinationally.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            SEG_SELECT_OUT <= {NUM_DIGITS{ANODE_OFF}};
            HEX_OUT        <= SEG_OFF;
            SCAN_START_OUT <= 1'b0;
        end else begin
            SEG_SELECT_OUT <= sel_next;
            HEX_OUT        <= hex_next;
            SCAN_START_OUT <= scan_entry;
        end
    end

endmodule
